mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM-stage controller between the EX/MEM and MEM/WB pipeline registers.
- Takes the registered aluout (address), rd2 (store data), memlen and memwe, and runs a variable-latency request/ack transaction on the data-memory port.
- Produces the aligned, extended load word (memrd) for MEM/WB.
- Raises a pipeline pause while a transaction is outstanding.

Parameters:
- TIMEOUT, 255: WAIT cycles without dm_ack before the access is abandoned (1..65535).
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- stall_i  input  1  external pipeline pause from other sources; holds the DONE state
- aluout_i  input  32  effective address from EX/MEM
- rd2_i  input  32  store data from EX/MEM
- memlen_i  input  3  [1:0]: 00 none, 01 byte, 10 half, 11 word; [2]: 1 = zero-extend load
- memwe_i  input  1  1 = store, 0 = load (only when memlen_i[1:0] != 0)
- memrd_o  output  32  load result to MEM/WB
- pause_o  output  1  stall request to all pipeline registers and PC
- misalign_o  output  1  one-cycle misaligned-access flag
- buserr_o  output  1  one-cycle timeout flag
- dm_req  output  1  memory request, registered
- dm_we  output  1  write enable, registered
- dm_addr  output  32  word address, {aluout[31:2], 2'b00}, registered
- dm_be  output  4  byte enables, registered
- dm_wdata  output  32  lane-replicated store data, registered
- dm_rdata  input  32  read data, valid with dm_ack
- dm_ack  input  1  transaction complete

Behaviour:
- Reset (async, rst=0): state IDLE; dm_req, dm_we, dm_addr, dm_be, dm_wdata, memrd register and counter all 0. memrd_o, pause_o, misalign_o and buserr_o read 0.
- An access is defined as memlen_i[1:0] != 0.
- Misaligned access: half with addr[0]=1, or word with addr[1:0] != 0.

States:
- IDLE:
  - No access: pause_o=0, memrd_o=0.
  - Misaligned access: misalign_o=1 (combinational), no request, pause_o=0, stay in IDLE.
  - Aligned access: pause_o=1; register dm_addr, dm_we=memwe_i, dm_be and dm_wdata; dm_req<=1; counter<=0; go to WAIT.
- WAIT:
  - pause_o=1; dm_req held at 1; counter increments each cycle.
  - dm_ack=1: dm_req<=0; memrd register <= extracted load data (0 for stores); go to DONE.
  - No ack and counter==TIMEOUT-1: dm_req<=0; memrd<=0; buserr_o=1 for that cycle; go to DONE.
- DONE:
  - pause_o=0; memrd_o = memrd register, so MEM/WB captures it.
  - stall_i=1: stay in DONE, output held, no new request (the EX/MEM entry has not changed).
  - Otherwise go to IDLE.

Lane rules (little-endian; a = addr[1:0]):
- Byte: be = 4'b0001<<a; wdata = {4{rd2[7:0]}}; load = dm_rdata[8a+7:8a], sign- or zero-extended per memlen_i[2].
- Half: be = a[1] ? 1100 : 0011; wdata = {2{rd2[15:0]}}; load = upper or lower half, extended.
- Word: be = 1111; wdata = rd2; load = dm_rdata.

Latency and handshake:
- Minimum occupancy is 3 cycles (IDLE issue, WAIT with ack, DONE), so 2 pause cycles.
- dm_ack is ignored outside WAIT.
- dm_req must not be dropped before dm_ack or timeout.

Other boundaries:
- Reset asserted in WAIT drops dm_req immediately and discards the transaction.
- dm_ack on the timeout cycle: the ack wins and buserr_o=0.
- Back-to-back accesses: the new access is issued in the IDLE cycle that follows DONE.

Test Plan:
- Load byte signed: addr=0x1003, memlen=001, dm_rdata=0x80FF_1234, ack one cycle after req. Expect dm_be=1000, dm_addr=0x1000, pause_o high 2 cycles, memrd_o=0xFFFF_FF80 in DONE.
- Load half unsigned: addr=0x2002, memlen=110, dm_rdata=0xBEEF_0000, ack after 5 WAIT cycles. Expect memrd_o=0x0000_BEEF, pause_o high 6 cycles.
- Store byte: addr=0x3001, rd2=0x1234_56AB, memwe=1, memlen=001. Expect dm_we=1, dm_be=0010, dm_wdata=0xABAB_ABAB, memrd_o=0.
- Misaligned word: addr=0x4002, memlen=011. Expect misalign_o=1 for one cycle, dm_req stays 0, pause_o=0.
- Timeout with TIMEOUT=4 and no ack. Expect dm_req high 4 cycles, buserr_o pulse, DONE with memrd_o=0, then IDLE.
- stall_i=1 for 3 cycles in DONE. Expect memrd_o held and no second dm_req. Also assert rst mid-WAIT: expect dm_req=0 immediately and state IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: issues one registered request/ack access per
// EX/MEM entry, pauses the pipeline while it is outstanding, and returns the aligned, extended load word.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [31:0] aluout_i,
  input  logic [31:0] rd2_i,
  input  logic [2:0]  memlen_i,
  input  logic        memwe_i,
  output logic [31:0] memrd_o,
  output logic        pause_o,
  output logic        misalign_o,
  output logic        buserr_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [31:0]       dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic [31:0]       memrd_q, memrd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        len_q, len_d;
  logic              access, misalign, timeout_hit;

  function automatic logic [3:0] lane_be(input logic [1:0] len, input logic [1:0] a);
    case (len)
      2'b01:   lane_be = 4'b0001 << a;
      2'b10:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] len, input logic [31:0] d);
    case (len)
      2'b01:   lane_wdata = {4{d[7:0]}};
      2'b10:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] len, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (len[1:0])
      2'b01:   load_extract = len[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b10:   load_extract = len[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = rd;
    endcase
  endfunction

  assign access   = memlen_i[1:0] != 2'b00;
  assign misalign = ((memlen_i[1:0] == 2'b10) && aluout_i[0]) ||
                    ((memlen_i[1:0] == 2'b11) && (aluout_i[1:0] != 2'b00));
  // ack takes priority over an expiring counter
  assign timeout_hit = (state_q == S_WAIT) && !dm_ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
      memrd_q    <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      memrd_q    <= memrd_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      len_q      <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    memrd_d    = memrd_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    len_d      = len_q;
    case (state_q)
      S_IDLE: begin
        if (access && !misalign) begin
          dm_req_d   = 1'b1;
          dm_we_d    = memwe_i;
          dm_addr_d  = {aluout_i[31:2], 2'b00};
          dm_be_d    = lane_be(memlen_i[1:0], aluout_i[1:0]);
          dm_wdata_d = lane_wdata(memlen_i[1:0], rd2_i);
          cnt_d      = '0;
          lane_d     = aluout_i[1:0];
          len_d      = memlen_i;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dm_ack) begin
          dm_req_d = 1'b0;
          memrd_d  = dm_we_q ? 32'd0 : load_extract(len_q, lane_q, dm_rdata);
          state_d  = S_DONE;
        end else if (timeout_hit) begin
          dm_req_d = 1'b0;
          memrd_d  = 32'd0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pause_o    = 1'b0;
    misalign_o = 1'b0;
    buserr_o   = 1'b0;
    memrd_o    = 32'd0;
    case (state_q)
      S_IDLE: begin
        pause_o    = access && !misalign;
        misalign_o = access && misalign;
      end
      S_WAIT: begin
        pause_o  = 1'b1;
        buserr_o = timeout_hit;
      end
      S_DONE:  memrd_o = memrd_q;
      default: ;
    endcase
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_be    = dm_be_q;
  assign dm_wdata = dm_wdata_q;

endmodule
